// File: rtl/scope_axi_arb_pkg.sv
// Shared types and constants for the scope AXI write arbiter.
package scope_axi_arb_pkg;

    // Default burst-length field width (beats = wlen + 1, up to 16).
    localparam int unsigned LW_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_REQ0 = 2'b01;
    localparam logic [1:0] GNT_REQ1 = 2'b10;

    // One-hot grant vector for a given arbiter state.
    function automatic logic [1:0] state_to_gnt(arb_state_e s);
        logic [1:0] g;
        case (s)
            StGnt0:  g = GNT_REQ0;
            StGnt1:  g = GNT_REQ1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/scope_axi_wr_arb.sv
// Two-requester round-robin AXI write arbiter: whole bursts are granted, and a
// pending request is picked up on the last beat so bursts run back to back.
module scope_axi_wr_arb
    import scope_axi_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64,
    parameter int unsigned SW = DW / 8,
    parameter int unsigned LW = LW_DEFAULT
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,

    input  logic [AW-1:0] req0_waddr_i,
    input  logic [DW-1:0] req0_wdata_i,
    input  logic [SW-1:0] req0_wsel_i,
    input  logic          req0_wvalid_i,
    input  logic [LW-1:0] req0_wlen_i,
    input  logic          req0_wfixed_i,
    output logic          req0_wrdy_o,
    output logic          req0_werr_o,

    input  logic [AW-1:0] req1_waddr_i,
    input  logic [DW-1:0] req1_wdata_i,
    input  logic [SW-1:0] req1_wsel_i,
    input  logic          req1_wvalid_i,
    input  logic [LW-1:0] req1_wlen_i,
    input  logic          req1_wfixed_i,
    output logic          req1_wrdy_o,
    output logic          req1_werr_o,

    output logic [AW-1:0] axi_waddr_o,
    output logic [DW-1:0] axi_wdata_o,
    output logic [SW-1:0] axi_wsel_o,
    output logic          axi_wvalid_o,
    output logic [LW-1:0] axi_wlen_o,
    output logic          axi_wfixed_o,
    input  logic          axi_wrdy_i,
    input  logic          axi_werr_i,

    output logic [1:0]    gnt_o,
    output logic          busy_o
);

    arb_state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          last_gnt_q, last_gnt_d;  // 0 = req0 granted last, 1 = req1
    logic          beat;
    logic          last_beat;
    logic          load;

    assign beat      = axi_wvalid_o & axi_wrdy_i;
    assign last_beat = beat && (cnt_q == len_q);
    // A new grant (including re-entering the same one) latches length and clears the count.
    assign load      = (state_d != StIdle) && ((state_q == StIdle) || last_beat);

    // State, length, counter and round-robin pointer registers
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: arbitrate from idle, or on the last beat of the current burst
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req0_wvalid_i && req1_wvalid_i) begin
                    state_d = last_gnt_q ? StGnt0 : StGnt1;
                end else if (req0_wvalid_i) begin
                    state_d = StGnt0;
                end else if (req1_wvalid_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (last_beat) begin
                    if (req1_wvalid_i) begin
                        state_d = StGnt1;
                    end else if (req0_wvalid_i) begin
                        state_d = StGnt0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGnt1: begin
                if (last_beat) begin
                    if (req0_wvalid_i) begin
                        state_d = StGnt0;
                    end else if (req1_wvalid_i) begin
                        state_d = StGnt1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat counter, burst length latch and round-robin pointer next-state
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        last_gnt_d = last_gnt_q;
        if (load) begin
            cnt_d      = '0;
            len_d      = (state_d == StGnt1) ? req1_wlen_i : req0_wlen_i;
            last_gnt_d = (state_d == StGnt1);
        end else if (beat) begin
            cnt_d = cnt_q + LW'(1);
        end
    end

    // Output mux: granted requester drives the master; handshakes route back to it only
    always_comb begin
        axi_waddr_o  = '0;
        axi_wdata_o  = '0;
        axi_wsel_o   = '0;
        axi_wvalid_o = 1'b0;
        axi_wlen_o   = '0;
        axi_wfixed_o = 1'b0;
        req0_wrdy_o  = 1'b0;
        req0_werr_o  = 1'b0;
        req1_wrdy_o  = 1'b0;
        req1_werr_o  = 1'b0;
        case (state_q)
            StGnt0: begin
                axi_waddr_o  = req0_waddr_i;
                axi_wdata_o  = req0_wdata_i;
                axi_wsel_o   = req0_wsel_i;
                axi_wvalid_o = req0_wvalid_i;
                axi_wlen_o   = len_q;
                axi_wfixed_o = req0_wfixed_i;
                req0_wrdy_o  = axi_wrdy_i;
                req0_werr_o  = axi_werr_i;
            end
            StGnt1: begin
                axi_waddr_o  = req1_waddr_i;
                axi_wdata_o  = req1_wdata_i;
                axi_wsel_o   = req1_wsel_i;
                axi_wvalid_o = req1_wvalid_i;
                axi_wlen_o   = len_q;
                axi_wfixed_o = req1_wfixed_i;
                req1_wrdy_o  = axi_wrdy_i;
                req1_werr_o  = axi_werr_i;
            end
            default: ;
        endcase
        gnt_o  = state_to_gnt(state_q);
        busy_o = (state_q != StIdle);
    end

endmodule

// File: doc/scope_axi_wr_arb.md
# scope_axi_wr_arb

Two-requester write arbiter that shares one AXI write master port between the oscilloscope channel-A and channel-B capture writers. It sits between the per-channel AXI write outputs of the scope and a single PS HP port. Bursts are granted whole and in round-robin order. Back-to-back bursts from different requesters are issued with no idle cycle.

## Interface
Parameters:
- AW, 32, address width
- DW, 64, data width
- SW, DW/8, byte-select width
- LW, 4, burst length width (beats = wlen+1, max 2^LW)

Ports (n = 0, 1):
- adc_clk_i  in  1  clock; single clock domain for the whole block
- adc_rstn_i  in  1  reset; asynchronous, active-low
- reqn_waddr_i  in  AW  burst start address
- reqn_wdata_i  in  DW  write data
- reqn_wsel_i  in  SW  byte select
- reqn_wvalid_i  in  1  data valid / request
- reqn_wlen_i  in  LW  burst length − 1
- reqn_wfixed_i  in  1  burst type (fixed / incremental)
- reqn_wrdy_o  out  1  beat accepted
- reqn_werr_o  out  1  write error
- axi_waddr_o, axi_wdata_o, axi_wsel_o, axi_wvalid_o, axi_wlen_o, axi_wfixed_o  out  AW/DW/SW/1/LW/1  muxed master side
- axi_wrdy_i  in  1  master ready
- axi_werr_i  in  1  master error
- gnt_o  out  2  one-hot current grant (bit n = requester n)
- busy_o  out  1  grant active

## Operation
- States: IDLE, GNT0, GNT1.
- Beat handshake: a beat transfers when axi_wvalid_o & axi_wrdy_i.
- IDLE:
  - If no reqn_wvalid_i is high, stay in IDLE.
  - If exactly one is high, go to that requester's GNT state.
  - If both are high, grant the requester that is not last_gnt.
  - last_gnt resets to 1, so req0 wins the first tie.
- On entering GNTn:
  - Latch reqn_wlen_i into len_q.
  - Clear beat counter cnt_q (LW bits).
  - Set last_gnt = n.
- In GNTn:
  - All axi_* outputs = reqn_* inputs, combinationally.
  - reqn_wrdy_o = axi_wrdy_i.
  - reqn_werr_o = axi_werr_i.
  - The non-granted requester's wrdy_o and werr_o are 0.
  - axi_wlen_o is driven from len_q, not the live input.
- Each transferred beat increments cnt_q.
- Last beat = transfer with cnt_q == len_q. On the last beat, re-arbitrate in the same cycle:
  - If the other requester's wvalid is high, go to its GNT state.
  - Else, if the same requester's wvalid is high, re-enter the same GNT state (new len latch, counter cleared).
  - Else, go to IDLE.
- A requester dropping wvalid mid-burst does not release the grant. The arbiter waits for the burst to complete.
- Outputs in IDLE: axi_wvalid_o = 0, all other axi_* = 0, both wrdy_o/werr_o = 0, gnt_o = 2'b00, busy_o = 0.
- Arithmetic: cnt_q and len_q are unsigned LW-bit. len_q = 2^LW−1 gives the maximum burst. cnt_q never wraps, because the last-beat compare occurs first.
- Error: axi_werr_i is forwarded only. It does not abort the burst or change state.

## Timing
- Request to grant: wvalid seen in IDLE at cycle N → GNTn registered at N+1. axi_wvalid_o is first high in N+1. Latency is 1 cycle.
- Burst to burst: 0 bubble cycles when a request is pending at the last beat.
- wrdy/werr paths are combinational (zero latency) through the mux.
- gnt_o, busy_o, len_q, cnt_q and last_gnt are registered and update on the clock edge after the deciding cycle.
- Reset asserted mid-burst:
  - Immediate return to IDLE, last_gnt = 1, counters = 0.
  - All outputs take their IDLE values asynchronously.
  - The partial burst is abandoned.
- After reset release, the first arbitration occurs on the first rising edge with wvalid high.

## Structure
- Shared package scope_axi_arb_pkg:
  - State enum (IDLE, GNT0, GNT1).
  - Default LW.
  - Grant encodings GNT_NONE = 2'b00, GNT_REQ0 = 2'b01, GNT_REQ1 = 2'b10.
- Single module, no sub-modules. The output mux, FSM and beat counter are inline; the mux is too small to split out.

## Test plan
- Single requester: req0 burst with wlen = 3, axi_wrdy_i = 1 → 4 beats on axi_*, gnt_o = 01 for 4 cycles starting one cycle after wvalid, then IDLE with busy_o = 0.
- Simultaneous request after reset: req0 and req1 both valid, wlen = 1 each → req0's 2 beats, then req1's 2 beats with no gap. gnt_o sequence 01, 01, 10, 10.
- Round-robin fairness: both valid continuously, wlen = 0 → grants alternate 01, 10, 01, 10 every cycle, with no requester granted twice in a row.
- Back-pressure and stall: req1 wlen = 7, axi_wrdy_i toggled 1,0,0,1 and req1 wvalid dropped for 2 cycles mid-burst → grant held until exactly 8 beats transfer. req0_wrdy_o stays 0 throughout.
- Error and reset: axi_werr_i pulse during a req0 beat → req0_werr_o = 1 and req1_werr_o = 0, burst continues. adc_rstn_i asserted at beat 2 of a wlen = 15 burst → outputs zero immediately, and the next tie grants req0.
